// File: rtl/line_pixel_writer.sv
// line_pixel_writer: buffers (x,y) plot points from the line drawer, drops
// consecutive repeats and off-screen points, and writes each surviving point
// to the framebuffer at y*H_RES + x.
//
// Handshakes:
// - A point transfers on a rising edge where pt_valid && pt_ready.
// - A framebuffer write transfers on a rising edge where fb_we && fb_ack.
//   fb_we, fb_addr and fb_data stay stable from assertion until that edge.
module line_pixel_writer #(
    parameter int H_RES   = 800,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pt_valid,
    input  logic [10:0]        pt_x,
    input  logic [9:0]         pt_y,
    input  logic               pt_last,
    input  logic [COLOR_W-1:0] pt_color,
    output logic               pt_ready,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_we,
    input  logic               fb_ack,
    output logic               line_done,
    output logic               busy,
    output logic [7:0]         clip_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 11 + 10 + 1 + COLOR_W;
    localparam logic [10:0]       X_LIM   = 11'(H_RES);
    localparam logic [9:0]        Y_LIM   = 10'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE} state_t;
    state_t state_q, state_d;

    // FIFO storage and pointers; the extra pointer MSB separates full from empty.
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [EW-1:0] head;
    logic          fifo_empty, accept, is_dup, push, pop;
    logic          pt_ready_q;

    // Last pushed point, used to drop consecutive repeats.
    logic          hist_valid_q;
    logic [10:0]   hist_x_q;
    logic [9:0]    hist_y_q;

    // Working copy of the popped entry.
    logic [10:0]        w_x_q;
    logic [9:0]         w_y_q;
    logic               w_last_q;
    logic [COLOR_W-1:0] w_color_q;
    logic               w_clipped;
    logic [ADDR_W-1:0]  calc_addr;

    logic [ADDR_W-1:0]  fb_addr_q;
    logic [COLOR_W-1:0] fb_data_q;
    logic               fb_we_q, fb_we_d;
    logic               line_done_q, line_done_d;
    logic               clip_inc, start_write;
    logic [7:0]         clip_cnt_q;

    function automatic logic is_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[PW-1] != r[PW-1]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    assign accept     = pt_valid && pt_ready_q;
    assign is_dup     = hist_valid_q && (pt_x == hist_x_q) && (pt_y == hist_y_q) && !pt_last;
    assign push       = accept && !is_dup;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign wr_ptr_d   = wr_ptr_q + PW'(push);
    assign rd_ptr_d   = rd_ptr_q + PW'(pop);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign w_clipped  = (w_x_q >= X_LIM) || (w_y_q >= Y_LIM);
    assign calc_addr  = ADDR_W'(w_y_q) * H_RES_A + ADDR_W'(w_x_q);

    // Pointers, registered ready (from next-cycle fullness) and duplicate history.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pt_ready_q   <= 1'b1;
            hist_valid_q <= 1'b0;
            hist_x_q     <= '0;
            hist_y_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pt_ready_q <= !is_full(wr_ptr_d, rd_ptr_d);
            if (accept) begin
                if (pt_last) begin
                    // The next line's first point must never be filtered.
                    hist_valid_q <= 1'b0;
                end else if (push) begin
                    hist_valid_q <= 1'b1;
                    hist_x_q     <= pt_x;
                    hist_y_q     <= pt_y;
                end
            end
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {pt_x, pt_y, pt_last, pt_color};
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM next state and control strobes.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        fb_we_d     = fb_we_q;
        line_done_d = 1'b0;
        clip_inc    = 1'b0;
        start_write = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (w_clipped) begin
                    clip_inc    = 1'b1;
                    line_done_d = w_last_q;
                    state_d     = S_IDLE;
                end else begin
                    start_write = 1'b1;
                    fb_we_d     = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // fb_we is always high here, so an ack outside a write is ignored.
                if (fb_ack) begin
                    fb_we_d     = 1'b0;
                    line_done_d = w_last_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Working registers, framebuffer outputs, line_done pulse and clip counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_x_q       <= '0;
            w_y_q       <= '0;
            w_last_q    <= 1'b0;
            w_color_q   <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            fb_we_q     <= 1'b0;
            line_done_q <= 1'b0;
            clip_cnt_q  <= '0;
        end else begin
            fb_we_q     <= fb_we_d;
            line_done_q <= line_done_d;
            if (pop) begin
                w_x_q     <= head[EW-1 -: 11];
                w_y_q     <= head[EW-12 -: 10];
                w_last_q  <= head[COLOR_W];
                w_color_q <= head[COLOR_W-1:0];
            end
            if (start_write) begin
                fb_addr_q <= calc_addr;
                fb_data_q <= w_color_q;
            end
            if (clip_inc && (clip_cnt_q != 8'hFF)) begin
                clip_cnt_q <= clip_cnt_q + 8'd1;
            end
        end
    end

    assign pt_ready  = pt_ready_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign fb_we     = fb_we_q;
    assign line_done = line_done_q;
    assign clip_cnt  = clip_cnt_q;
    assign busy      = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_line_pixel_writer.sv
// Bench for line_pixel_writer: scenario tasks drive points, push expected
// framebuffer writes to a queue, and a negedge monitor pops and compares each
// write as it completes.
module tb_line_pixel_writer;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 8;
    localparam int EW      = ADDR_W + COLOR_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               pt_valid = 1'b0;
    logic [10:0]        pt_x = '0;
    logic [9:0]         pt_y = '0;
    logic               pt_last = 1'b0;
    logic [COLOR_W-1:0] pt_color = '0;
    logic               pt_ready;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_we;
    logic               fb_ack = 1'b1;
    logic               line_done;
    logic               busy;
    logic [7:0]         clip_cnt;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int ld_cnt = 0;
    logic rand_ack = 1'b0;

    // Clock and reset block.
    always #5 clk = ~clk;

    line_pixel_writer #(
        .H_RES(800), .V_RES(480), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
        .pt_color(pt_color), .pt_ready(pt_ready),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ack(fb_ack),
        .line_done(line_done), .busy(busy), .clip_cnt(clip_cnt)
    );

    // Random memory acknowledge when enabled.
    always @(posedge clk) begin
        if (rand_ack) begin
            #2;
            fb_ack = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor: each completed write is checked against the queue head.
    always @(negedge clk) begin
        if (fb_we === 1'b1 && fb_ack === 1'b1) begin
            wr_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%0h", fb_addr, fb_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({fb_addr, fb_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL write_order got addr=%0d data=%0h exp addr=%0d data=%0h",
                             fb_addr, fb_data, mon_exp[EW-1:COLOR_W], mon_exp[COLOR_W-1:0]);
                end
            end
        end
        if (line_done === 1'b1) ld_cnt++;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int x, input int y, input logic [7:0] color);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(y * 800 + x);
        exp_q.push_back({a, color});
    endtask

    // Driver: presents one point and holds it until accepted (bounded).
    task automatic send_point(input int x, input int y, input logic last, input logic [7:0] color);
        bit done;
        done = 1'b0;
        pt_valid = 1'b1;
        pt_x = 11'(x);
        pt_y = 10'(y);
        pt_last = last;
        pt_color = color;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (pt_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        pt_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout point=(%0d,%0d) got ready=0 exp ready=1", x, y);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (!busy && !fb_we && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL idle_timeout pending=%0d busy=%0b exp pending=0 busy=0", exp_q.size(), busy);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        sync();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL rst_pt_ready got=%b exp=1", pt_ready); end
        total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL rst_fb_we got=%b exp=0", fb_we); end
        total++; if (fb_addr !== '0) begin bad++; $display("FAIL rst_fb_addr got=%0d exp=0", fb_addr); end
        total++; if (fb_data !== '0) begin bad++; $display("FAIL rst_fb_data got=%0h exp=0", fb_data); end
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL rst_line_done got=%b exp=0", line_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (clip_cnt !== 8'd0) begin bad++; $display("FAIL rst_clip_cnt got=%0d exp=0", clip_cnt); end
        sync();
        reset = 1'b0;
        sync();
    endtask

    task automatic test_single();
        logic [4:0] we_pat;
        logic [4:0] ld_pat;
        we_pat = 5'b00100;
        ld_pat = 5'b01000;
        fb_ack = 1'b1;
        wr_cnt = 0;
        ld_cnt = 0;
        expect_write(10, 5, 8'h3C);
        send_point(10, 5, 1'b1, 8'h3C);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (fb_we !== we_pat[c]) begin bad++; $display("FAIL single_we_c%0d got=%b exp=%b", c, fb_we, we_pat[c]); end
            total++;
            if (line_done !== ld_pat[c]) begin bad++; $display("FAIL single_ld_c%0d got=%b exp=%b", c, line_done, ld_pat[c]); end
            if (c == 2) begin
                total++; if (fb_addr !== 19'd4010) begin bad++; $display("FAIL single_addr got=%0d exp=4010", fb_addr); end
                total++; if (fb_data !== 8'h3C) begin bad++; $display("FAIL single_data got=%0h exp=3c", fb_data); end
            end
            if (c == 4) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
            end
        end
        wait_idle(50);
        total++; if (wr_cnt !== 1) begin bad++; $display("FAIL single_writes got=%0d exp=1", wr_cnt); end
        total++; if (ld_cnt !== 1) begin bad++; $display("FAIL single_line_done got=%0d exp=1", ld_cnt); end
    endtask

    task automatic test_diagonal();
        fb_ack = 1'b1;
        wr_cnt = 0;
        ld_cnt = 0;
        expect_write(0, 0, 8'h10);
        expect_write(1, 1, 8'h11);
        expect_write(2, 2, 8'h12);
        expect_write(3, 3, 8'h13);
        send_point(0, 0, 1'b0, 8'h10);
        send_point(1, 1, 1'b0, 8'h11);
        send_point(1, 1, 1'b0, 8'h11);
        send_point(2, 2, 1'b0, 8'h12);
        send_point(3, 3, 1'b1, 8'h13);
        wait_idle(200);
        total++; if (wr_cnt !== 4) begin bad++; $display("FAIL diag_writes got=%0d exp=4", wr_cnt); end
        total++; if (ld_cnt !== 1) begin bad++; $display("FAIL diag_line_done got=%0d exp=1", ld_cnt); end
    endtask

    task automatic test_clip();
        fb_ack = 1'b1;
        wr_cnt = 0;
        ld_cnt = 0;
        expect_write(799, 479, 8'hA5);
        send_point(800, 0, 1'b0, 8'h01);
        send_point(0, 480, 1'b0, 8'h02);
        send_point(799, 479, 1'b1, 8'hA5);
        wait_idle(200);
        total++; if (clip_cnt !== 8'd2) begin bad++; $display("FAIL clip_count got=%0d exp=2", clip_cnt); end
        total++; if (wr_cnt !== 1) begin bad++; $display("FAIL clip_writes got=%0d exp=1", wr_cnt); end
        total++; if (ld_cnt !== 1) begin bad++; $display("FAIL clip_line_done got=%0d exp=1", ld_cnt); end
    endtask

    task automatic test_backpressure();
        int  i;
        bit  stable_ok;
        bit  seen_we;
        i = 0;
        stable_ok = 1'b1;
        seen_we = 1'b0;
        fb_ack = 1'b0;
        wr_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (i < 20) begin
                pt_valid = 1'b1;
                pt_x = 11'(i);
                pt_y = 10'd10;
                pt_last = 1'b0;
                pt_color = 8'(i);
            end else begin
                pt_valid = 1'b0;
            end
            @(negedge clk);
            if (fb_we) begin
                seen_we = 1'b1;
                if (fb_addr !== 19'd8000) stable_ok = 1'b0;
            end
            if (pt_valid && pt_ready) begin
                expect_write(i, 10, 8'(i));
                i++;
            end
            sync();
        end
        pt_valid = 1'b0;
        @(negedge clk);
        total++; if (i !== 17) begin bad++; $display("FAIL bp_accepted got=%0d exp=17", i); end
        total++; if (pt_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", pt_ready); end
        total++; if (fb_we !== 1'b1) begin bad++; $display("FAIL bp_we_held got=%b exp=1", fb_we); end
        total++; if (!(stable_ok && seen_we)) begin bad++; $display("FAIL bp_addr_stable got=%0b exp=1", stable_ok && seen_we); end
        sync();
        fb_ack = 1'b1;
        wait_idle(300);
        total++; if (wr_cnt !== 17) begin bad++; $display("FAIL bp_writes got=%0d exp=17", wr_cnt); end
        total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", pt_ready); end
    endtask

    task automatic test_random_ack();
        int clips;
        int y;
        logic [7:0] c0;
        logic [7:0] col;
        clips = 0;
        c0 = clip_cnt;
        wr_cnt = 0;
        ld_cnt = 0;
        rand_ack = 1'b1;
        for (int k = 0; k < 12; k++) begin
            y = $urandom_range(0, 520);
            col = 8'($urandom_range(0, 255));
            if (y >= 480) clips++;
            else expect_write(k * 5 + 1, y, col);
            send_point(k * 5 + 1, y, (k == 11), col);
        end
        wait_idle(2000);
        total++; if (wr_cnt !== 12 - clips) begin bad++; $display("FAIL rand_writes got=%0d exp=%0d", wr_cnt, 12 - clips); end
        total++; if (ld_cnt !== 1) begin bad++; $display("FAIL rand_line_done got=%0d exp=1", ld_cnt); end
        total++; if (clip_cnt !== 8'(c0 + 8'(clips))) begin bad++; $display("FAIL rand_clip_cnt got=%0d exp=%0d", clip_cnt, c0 + clips); end
        rand_ack = 1'b0;
        sync();
        sync();
        fb_ack = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        fb_ack = 1'b0;
        wr_cnt = 0;
        ld_cnt = 0;
        send_point(0, 9, 1'b0, 8'h01);
        send_point(1, 9, 1'b0, 8'h02);
        send_point(3, 9, 1'b0, 8'h03);
        send_point(4, 9, 1'b0, 8'h04);
        send_point(5, 9, 1'b0, 8'h05);
        send_point(2, 2, 1'b0, 8'h06);
        repeat (3) sync();
        @(negedge clk);
        total++; if (fb_we !== 1'b1) begin bad++; $display("FAIL mid_we_before got=%b exp=1", fb_we); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL mid_we_after got=%b exp=0", fb_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
        total++; if (pt_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", pt_ready); end
        total++; if (clip_cnt !== 8'd0) begin bad++; $display("FAIL mid_clip_after got=%0d exp=0", clip_cnt); end
        sync();
        fb_ack = 1'b1;
        expect_write(2, 2, 8'h77);
        send_point(2, 2, 1'b1, 8'h77);
        wait_idle(100);
        total++; if (wr_cnt !== 1) begin bad++; $display("FAIL mid_writes got=%0d exp=1", wr_cnt); end
        total++; if (ld_cnt !== 1) begin bad++; $display("FAIL mid_line_done got=%0d exp=1", ld_cnt); end
    endtask

    task automatic test_consecutive_lines();
        fb_ack = 1'b1;
        wr_cnt = 0;
        ld_cnt = 0;
        expect_write(6, 6, 8'h21);
        expect_write(7, 7, 8'h22);
        expect_write(7, 7, 8'h31);
        expect_write(8, 8, 8'h32);
        send_point(6, 6, 1'b0, 8'h21);
        send_point(7, 7, 1'b1, 8'h22);
        send_point(7, 7, 1'b0, 8'h31);
        send_point(8, 8, 1'b1, 8'h32);
        wait_idle(200);
        total++; if (wr_cnt !== 4) begin bad++; $display("FAIL lines_writes got=%0d exp=4", wr_cnt); end
        total++; if (ld_cnt !== 2) begin bad++; $display("FAIL lines_line_done got=%0d exp=2", ld_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_diagonal();
        test_clip();
        test_backpressure();
        test_random_ack();
        test_reset_mid_write();
        test_consecutive_lines();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
